// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, with first/last-bit strobes and idle gap.
// Latency: first bit on sout 1 clk after the load handshake; one word per SZE+GAP+1 clks.
// Backpressure: load_ready is high only in IDLE; load_valid/load_data are ignored otherwise.
module piso_tx #(
  parameter int   SZE      = 8,
  parameter int   GAP      = 1,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  input  logic [SZE-1:0] load_data,
  output logic           load_ready,
  output logic           sout,
  output logic           sout_valid,
  output logic           frame_start,
  output logic           frame_end,
  output logic           busy
);

  localparam int BW = ($clog2(SZE) < 1) ? 1 : $clog2(SZE);
  localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [BW-1:0] BIT_LD = BW'(SZE - 1);
  localparam logic [GW-1:0] GAP_LD = (GAP > 0) ? GW'(GAP - 1) : '0;

  if (SZE < 2 || SZE > 32 || GAP < 0 || GAP > 15) begin : g_bad_param
    $error("piso_tx: illegal parameters SZE=%0d GAP=%0d", SZE, GAP);
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [SZE-1:0]  r_shreg;
  logic [BW-1:0]   r_bitcnt;
  logic [GW-1:0]   r_gapcnt;
  logic            r_sout_valid;
  logic            r_frame_start;
  logic            r_frame_end;
  logic            r_busy;
  logic            w_xfer;

  // Ready depends on state only, so upstream can never form a combinational loop through us.
  assign load_ready = (r_state == S_IDLE);
  assign w_xfer     = load_valid & load_ready;

  // The shift register's MSB is the line itself: it is idle-filled after every word,
  // so sout reads IDLE_LVL in IDLE and GAP without a separate mux.
  assign sout        = r_shreg[SZE-1];
  assign sout_valid  = r_sout_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign busy        = r_busy;

  // Transmit FSM with registered framing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_shreg       <= {SZE{IDLE_LVL}};
      r_bitcnt      <= '0;
      r_gapcnt      <= '0;
      r_sout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state       <= S_SHIFT;
            r_shreg       <= load_data;
            r_bitcnt      <= BIT_LD;
            r_sout_valid  <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_end   <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Shift on every bit cycle including the LSB, leaving the register idle-filled.
          r_shreg       <= {r_shreg[SZE-2:0], IDLE_LVL};
          r_frame_start <= 1'b0;
          if (r_bitcnt == '0) begin
            r_sout_valid <= 1'b0;
            r_frame_end  <= 1'b0;
            if (GAP > 0) begin
              r_state  <= S_GAP;
              r_gapcnt <= GAP_LD;
              r_busy   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_bitcnt    <= r_bitcnt - BW'(1);
            r_frame_end <= (r_bitcnt == BW'(1));
          end
        end
        S_GAP: begin
          if (r_gapcnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gapcnt <= r_gapcnt - GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: vector table, randomized run against a timeline model, and corner sequences.
// Three instances: default (SZE=8, GAP=1), SZE=4/GAP=0, and IDLE_LVL=0 with GAP=2.
// Outputs are sampled #1 after the falling edge; inputs change on the falling edge.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_vld, a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy;
  logic [7:0] a_dat;
  logic       b_vld, b_rdy, b_sout, b_sv, b_fs, b_fe, b_busy;
  logic [3:0] b_dat;
  logic       c_vld, c_rdy, c_sout, c_sv, c_fs, c_fe, c_busy;
  logic [7:0] c_dat;

  piso_tx #(.SZE(8), .GAP(1), .IDLE_LVL(1'b1)) u0 (
    .clk(clk), .rst(rst), .load_valid(a_vld), .load_data(a_dat), .load_ready(a_rdy),
    .sout(a_sout), .sout_valid(a_sv), .frame_start(a_fs), .frame_end(a_fe), .busy(a_busy));

  piso_tx #(.SZE(4), .GAP(0), .IDLE_LVL(1'b1)) u1 (
    .clk(clk), .rst(rst), .load_valid(b_vld), .load_data(b_dat), .load_ready(b_rdy),
    .sout(b_sout), .sout_valid(b_sv), .frame_start(b_fs), .frame_end(b_fe), .busy(b_busy));

  piso_tx #(.SZE(8), .GAP(2), .IDLE_LVL(1'b0)) u2 (
    .clk(clk), .rst(rst), .load_valid(c_vld), .load_data(c_dat), .load_ready(c_rdy),
    .sout(c_sout), .sout_valid(c_sv), .frame_start(c_fs), .frame_end(c_fe), .busy(c_busy));

  int n_cmp = 0;
  int n_bad = 0;

  // Packed view {ready, sout, sout_valid, frame_start, frame_end, busy}.
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {rdy,sout,vld,fs,fe,busy}=%b want %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[12];

  localparam int A_SZE = 8;
  localparam int A_GAP = 1;

  initial begin
    logic [7:0]  w;
    logic [5:0]  e;
    logic [10:0] e_so, e_sv, e_fs, e_fe;
    int          n, start, nxt;
    logic [7:0]  word;
    logic        m_rdy, m_bit, m_sv, m_busy;

    // Single A5 word; data changes while shifting must not leak into the frame.
    tbl[0]  = '{1'b1, 8'hA5, 6'b110000};
    tbl[1]  = '{1'b1, 8'h5A, 6'b011101};
    tbl[2]  = '{1'b1, 8'h5A, 6'b001001};
    tbl[3]  = '{1'b1, 8'h00, 6'b011001};
    tbl[4]  = '{1'b1, 8'hFF, 6'b001001};
    tbl[5]  = '{1'b1, 8'h12, 6'b001001};
    tbl[6]  = '{1'b1, 8'h34, 6'b011001};
    tbl[7]  = '{1'b1, 8'h56, 6'b001001};
    tbl[8]  = '{1'b1, 8'h78, 6'b011011};
    tbl[9]  = '{1'b0, 8'h00, 6'b010001};
    tbl[10] = '{1'b0, 8'h00, 6'b110000};
    tbl[11] = '{1'b0, 8'h00, 6'b110000};

    rst = 1'b0;
    a_vld = 1'b0; a_dat = 8'h00;
    b_vld = 1'b0; b_dat = 4'h0;
    c_vld = 1'b0; c_dat = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_u0", {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, 6'b110000);
    chk("reset_u1", {b_rdy, b_sout, b_sv, b_fs, b_fe, b_busy}, 6'b110000);
    chk("reset_u2", {c_rdy, c_sout, c_sv, c_fs, c_fe, c_busy}, 6'b100000);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single word.
    for (int i = 0; i < 12; i++) begin
      a_vld = tbl[i].vld;
      a_dat = tbl[i].dat;
      #1 chk($sformatf("single_a5[%0d]", i), {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, tbl[i].exp);
      @(negedge clk);
    end

    // Randomized traffic against a timeline model: a word accepted in cycle t occupies
    // cycles t+1..t+SZE on the line and the block is ready again at t+SZE+GAP+1.
    n = 0; start = -1000; nxt = 0; word = 8'h00;
    for (int k = 0; k < 640; k++) begin
      if (k < 600) begin
        a_vld = ($urandom_range(0, 3) != 0);
        a_dat = 8'($urandom);
      end else begin
        a_vld = 1'b0;
        a_dat = 8'($urandom);
      end
      m_rdy  = (n >= nxt);
      m_busy = (n >= start) && (n < nxt);
      m_sv   = (n >= start) && (n < start + A_SZE);
      m_bit  = m_sv ? word[A_SZE - 1 - (n - start)] : 1'b1;
      e = {m_rdy, m_bit, m_sv, m_sv && (n == start), m_sv && (n == start + A_SZE - 1), m_busy};
      #1 chk($sformatf("random[%0d]", k), {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, e);
      if (m_rdy && a_vld) begin
        word  = a_dat;
        start = n + 1;
        nxt   = n + 1 + A_SZE + A_GAP;
      end
      n++;
      @(negedge clk);
    end

    // Upstream stall in IDLE.
    for (int i = 0; i < 5; i++) begin
      a_vld = 1'b0;
      a_dat = 8'($urandom);
      #1 chk($sformatf("stall[%0d]", i), {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, 6'b110000);
      @(negedge clk);
    end

    // Mid-word reset on C3, then a clean 3C.
    w = 8'hC3;
    a_vld = 1'b1; a_dat = w;
    #1 chk("c3_load", {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, 6'b110000);
    @(negedge clk);
    a_vld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      e = {1'b0, w[8 - i], 1'b1, (i == 1), 1'b0, 1'b1};
      #1 chk($sformatf("c3_bit[%0d]", i), {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, e);
      @(negedge clk);
    end
    rst = 1'b0;
    #1 chk("midreset_async", {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, 6'b110000);
    @(negedge clk);
    #1 chk("midreset_held", {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, 6'b110000);
    rst = 1'b1;
    w = 8'h3C;
    for (int i = 0; i <= 10; i++) begin
      a_vld = (i == 0);
      a_dat = w;
      if (i == 0 || i == 10) e = 6'b110000;
      else if (i == 9)       e = 6'b010001;
      else                   e = {1'b0, w[8 - i], 1'b1, (i == 1), (i == 8), 1'b1};
      #1 chk($sformatf("after_reset_3c[%0d]", i), {a_rdy, a_sout, a_sv, a_fs, a_fe, a_busy}, e);
      @(negedge clk);
    end

    // SZE=4, GAP=0: 9 then 6 streamed; one IDLE cycle between words.
    e_so = 11'b10110110011;
    e_sv = 11'b01111011110;
    e_fs = 11'b00001000010;
    e_fe = 11'b01000010000;
    for (int i = 0; i <= 10; i++) begin
      b_vld = (i <= 5);
      b_dat = (i < 5) ? 4'h9 : 4'h6;
      e = {~e_sv[i], e_so[i], e_sv[i], e_fs[i], e_fe[i], e_sv[i]};
      #1 chk($sformatf("gap0_stream[%0d]", i), {b_rdy, b_sout, b_sv, b_fs, b_fe, b_busy}, e);
      @(negedge clk);
    end
    b_vld = 1'b0;

    // IDLE_LVL=0, GAP=2: line stays low outside data, data bits unchanged.
    w = 8'hA5;
    for (int i = 0; i <= 12; i++) begin
      c_vld = (i == 0);
      c_dat = w;
      if (i == 0 || i >= 11)      e = 6'b100000;
      else if (i == 9 || i == 10) e = 6'b000001;
      else                        e = {1'b0, w[8 - i], 1'b1, (i == 1), (i == 8), 1'b1};
      #1 chk($sformatf("idle0_word[%0d]", i), {c_rdy, c_sout, c_sv, c_fs, c_fe, c_busy}, e);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
